output_port_bank: RTL and testbench
===================================

Name: output_port_bank

Overview:
- Parametrised memory-mapped output peripheral: NUM_CH output data registers of DATA_W bits, written by the CPU store path via WR_en/addr/din.
- Each channel drives a valid/ready handshake to an external consumer (LED/seven-segment driver, UART TX, etc.).
- A status register reports per-channel pending and overflow flags; CPU load path reads data or status through dout.
- Sits on the data-memory bus beside RAM, selected by the address decoder.

Parameters:
- NUM_CH, 2, number of output channels; 1..DATA_W/2.
- DATA_W, 32, width of data registers, din and dout.
- ADDR_W, 2, local address width; must satisfy NUM_CH+1 <= 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- WR_en  in  1  CPU write strobe; sampled on rising clk edge.
- addr  in  ADDR_W  local register index.
- din  in  DATA_W  CPU write data.
- dout  out  DATA_W  CPU read data; combinational from addr.
- out_data  out  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  NUM_CH  channel i holds unconsumed data.
- out_ready  in  NUM_CH  consumer accepts channel i when out_valid[i] & out_ready[i].

Behaviour:
- Address map: addr 0..NUM_CH-1 = data reg i; addr NUM_CH = STATUS; all other addresses unmapped.
- STATUS layout: bits [NUM_CH-1:0] = pending[i]; bits [2*NUM_CH-1:NUM_CH] = overflow[i]; remaining bits read 0.
- Reset (async, any time including mid-handshake): all data regs, pending and overflow = 0. Hence out_data = 0, out_valid = 0, dout = 0 for every address.
- Read: dout = data reg for addr < NUM_CH, STATUS for addr == NUM_CH, 0 when unmapped. Zero-cycle latency, no side effects.
- Data write (WR_en, addr = i < NUM_CH):
  - Next edge: data[i] <= din, pending[i] <= 1.
  - If pending[i] was already 1 and no handshake occurs on i that cycle: overflow[i] <= 1 (sticky).
- Channel outputs: out_valid[i] = pending[i]; out_data[i] = data[i]. Registered, so values are visible the cycle after the write edge.
- Handshake: on an edge where out_valid[i] & out_ready[i], pending[i] <= 0. out_data[i] is unchanged.
- Simultaneous write and handshake on the same channel, same edge:
  - Old value is consumed.
  - New value is stored; pending[i] stays 1.
  - No overflow is set.
- Writes and handshakes on different channels in the same cycle are independent.
- STATUS write (WR_en, addr == NUM_CH):
  - Write-1-to-clear: overflow[i] <= 0 where din[NUM_CH+i] == 1.
  - Pending bits are not writable; din[NUM_CH-1:0] is ignored.
  - If a clear and a new overflow event on channel i coincide, the overflow set wins.
- Unmapped write: ignored; no state change.
- out_ready asserted while out_valid = 0: no effect.
- Single-cycle throughput: a channel can be written every cycle. With out_ready held high, each value is presented for exactly one cycle and no overflow occurs.

Test Plan:
- Reset: assert rst mid-run with channel 1 pending -> immediately out_valid = 2'b00, out_data = 0, dout = 0 at addr 0, 1, 2, 3.
- Write 32'h0000_00A5 to addr 0, out_ready = 0 -> next cycle out_valid = 2'b01, out_data[31:0] = 32'hA5, STATUS read = 32'h1. Raise out_ready[0] for 1 cycle -> out_valid = 0, STATUS = 32'h0, data reg 0 still reads 32'hA5.
- Write addr 1 = 32'h11, then addr 1 = 32'h22, out_ready = 0 -> out_data[63:32] = 32'h22, STATUS = 32'h0000_0008 | 32'h2 = 32'hA. Write STATUS din = 32'h8 -> STATUS = 32'h2.
- Channel 0 pending, out_ready[0] = 1, same edge write addr 0 = 32'h5 -> out_valid[0] stays 1, out_data[31:0] = 32'h5, overflow[0] = 0.
- Write addr 3 (unmapped) = 32'hFFFF_FFFF -> no state change; dout at addr 3 = 0. Write STATUS din = 32'h3 -> pending bits unchanged.
- Back-to-back writes 1, 2, 3 to addr 0 with out_ready[0] = 1 -> consumer sees 1, 2, 3 on consecutive cycles; STATUS = 0 afterwards.

Source files
------------

// File: rtl/output_port_bank.sv
// Memory-mapped output peripheral: NUM_CH data registers, each driving a
// valid/ready channel, plus a STATUS register with pending and sticky overflow flags.
module output_port_bank #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WR_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
);

  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [DATA_W-1:0] data_d [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overflow_q, overflow_d;

  logic [NUM_CH-1:0] wr_hit, hs, clr;
  logic              sts_wr;
  logic [DATA_W-1:0] status;

  always_comb begin
    sts_wr = WR_en && (addr == ADDR_W'(NUM_CH));
    hs     = pending_q & out_ready;
    wr_hit = '0;
    clr    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = WR_en && (addr == ADDR_W'(i));
      clr[i]    = sts_wr && din[NUM_CH+i];
    end
  end

  // A write that lands on a consumed slot refills it without overflow;
  // a new overflow event takes priority over a W1C clear.
  always_comb begin
    data_d     = data_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_hit[i]) data_d[i] = din;
      pending_d[i]  = wr_hit[i] | (pending_q[i] & ~hs[i]);
      overflow_d[i] = (wr_hit[i] & pending_q[i] & ~hs[i]) |
                      (overflow_q[i] & ~clr[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) data_q[i] <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) data_q[i] <= data_d[i];
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    status                    = '0;
    status[NUM_CH-1:0]        = pending_q;
    status[2*NUM_CH-1:NUM_CH] = overflow_q;
  end

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_W'(i)) dout = data_q[i];
    end
    if (addr == ADDR_W'(NUM_CH)) dout = status;
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      out_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

  assign out_valid = pending_q;

endmodule

// File: tb/tb_output_port_bank.sv
// Self-checking bench for output_port_bank: consumed values are checked
// against per-channel scoreboards; register state is checked inline per scenario.
module tb_output_port_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WR_en = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [63:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];

  output_port_bank #(.NUM_CH(2), .DATA_W(32), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .WR_en(WR_en), .addr(addr), .din(din), .dout(dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  // Consumer monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid[0] && out_ready[0]) begin
        checks++;
        if (exp0.size() == 0) begin
          failures++;
          $display("FAIL consume0: got %h, required no consumption", out_data[31:0]);
        end else begin
          logic [31:0] e0;
          e0 = exp0.pop_front();
          if (out_data[31:0] !== e0) begin
            failures++;
            $display("FAIL consume0: got %h, required %h", out_data[31:0], e0);
          end
        end
      end
      if (out_valid[1] && out_ready[1]) begin
        checks++;
        if (exp1.size() == 0) begin
          failures++;
          $display("FAIL consume1: got %h, required no consumption", out_data[63:32]);
        end else begin
          logic [31:0] e1;
          e1 = exp1.pop_front();
          if (out_data[63:32] !== e1) begin
            failures++;
            $display("FAIL consume1: got %h, required %h", out_data[63:32], e1);
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    WR_en = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    WR_en = 1'b0;
  endtask

  task automatic pulse_ready(input logic [1:0] r);
    @(posedge clk); #1;
    out_ready = r;
    @(posedge clk); #1;
    out_ready = '0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (out_valid !== 2'b00 || out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_init: valid=%b data=%h, required 00 / 0", out_valid, out_data);
    end
    bus_write(2'd1, 32'h55);
    checks++;
    if (out_valid !== 2'b10) begin
      failures++;
      $display("FAIL reset_prefill: valid=%b, required 10", out_valid);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 2'b00 || out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_async: valid=%b data=%h, required 00 / 0", out_valid, out_data);
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      rd = dout;
      checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL reset_dout%0d: got %h, required 0", a, rd);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_write_handshake;
    bus_write(2'd0, 32'h0000_00A5);
    addr = 2'd2; #1;
    checks++;
    if (out_valid !== 2'b01 || out_data[31:0] !== 32'hA5 || dout !== 32'h1) begin
      failures++;
      $display("FAIL write0: valid=%b data=%h status=%h, required 01 / a5 / 1",
               out_valid, out_data[31:0], dout);
    end
    exp0.push_back(32'hA5);
    pulse_ready(2'b01);
    addr = 2'd2; #1;
    checks++;
    if (out_valid !== 2'b00 || dout !== 32'h0) begin
      failures++;
      $display("FAIL handshake0: valid=%b status=%h, required 00 / 0", out_valid, dout);
    end
    addr = 2'd0; #1;
    checks++;
    if (dout !== 32'hA5 || out_data[31:0] !== 32'hA5) begin
      failures++;
      $display("FAIL hold0: dout=%h data=%h, required a5", dout, out_data[31:0]);
    end
  endtask

  task automatic test_overflow;
    bus_write(2'd1, 32'h11);
    bus_write(2'd1, 32'h22);
    addr = 2'd2; #1;
    checks++;
    if (out_data[63:32] !== 32'h22 || dout !== 32'hA) begin
      failures++;
      $display("FAIL overflow1: data=%h status=%h, required 22 / a", out_data[63:32], dout);
    end
    bus_write(2'd2, 32'h8);
    addr = 2'd2; #1;
    checks++;
    if (dout !== 32'h2) begin
      failures++;
      $display("FAIL w1c: status=%h, required 2", dout);
    end
    exp1.push_back(32'h22);
    pulse_ready(2'b10);
    addr = 2'd2; #1;
    checks++;
    if (dout !== 32'h0) begin
      failures++;
      $display("FAIL drain1: status=%h, required 0", dout);
    end
  endtask

  task automatic test_simultaneous;
    bus_write(2'd0, 32'h7);
    exp0.push_back(32'h7);
    @(posedge clk); #1;
    WR_en = 1'b1; addr = 2'd0; din = 32'h5; out_ready = 2'b01;
    @(posedge clk); #1;
    WR_en = 1'b0; out_ready = '0;
    addr = 2'd2; #1;
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'h5 || dout !== 32'h1) begin
      failures++;
      $display("FAIL simul0: valid0=%b data=%h status=%h, required 1 / 5 / 1",
               out_valid[0], out_data[31:0], dout);
    end
    exp0.push_back(32'h5);
    pulse_ready(2'b01);
  endtask

  task automatic test_unmapped;
    logic [31:0] want [4];
    want[0] = 32'h5; want[1] = 32'h22; want[2] = 32'h0; want[3] = 32'h0;
    bus_write(2'd3, 32'hFFFF_FFFF);
    checks++;
    if (out_valid !== 2'b00 || out_data !== 64'h0000_0022_0000_0005) begin
      failures++;
      $display("FAIL unmapped_out: valid=%b data=%h, required 00 / 0000002200000005",
               out_valid, out_data);
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      checks++;
      if (dout !== want[a]) begin
        failures++;
        $display("FAIL unmapped_rd%0d: got %h, required %h", a, dout, want[a]);
      end
    end
    bus_write(2'd1, 32'h33);
    bus_write(2'd2, 32'h3);
    addr = 2'd2; #1;
    checks++;
    if (dout !== 32'h2 || out_valid !== 2'b10) begin
      failures++;
      $display("FAIL pending_ro: status=%h valid=%b, required 2 / 10", dout, out_valid);
    end
    exp1.push_back(32'h33);
    pulse_ready(2'b10);
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    out_ready = 2'b01;
    for (int v = 1; v <= 3; v++) begin
      WR_en = 1'b1; addr = 2'd0; din = 32'(v);
      exp0.push_back(32'(v));
      @(posedge clk); #1;
    end
    WR_en = 1'b0;
    @(posedge clk); #1;
    out_ready = '0;
    addr = 2'd2; #1;
    checks++;
    if (dout !== 32'h0 || out_valid !== 2'b00) begin
      failures++;
      $display("FAIL b2b_status: status=%h valid=%b, required 0 / 00", dout, out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_write_handshake;
    test_overflow;
    test_simultaneous;
    test_unmapped;
    test_back_to_back;
    repeat (2) @(posedge clk);
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: left %0d/%0d, required 0/0", exp0.size(), exp1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
